spi_frame_assembler: RTL and testbench

- Sits directly downstream of the SPI slave byte receiver. It consumes each received byte on the slave's one-cycle byte-done pulse.
- Groups bytes into 4-byte frames: 3 data bytes (MSB first) plus 1 XOR check byte. It verifies the check byte and presents the 24-bit word with a status.
- Drives the 32-bit reply word back into the SPI slave's transmit load input. The reply is the last good word followed by its computed check byte.

---
 rtl/spi_frame_assembler.sv | 151 +++++++++++++++
 tb/tb_spi_frame_assembler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_assembler.sv
// rtl/spi_frame_assembler.sv - SPI byte-to-frame assembler with XOR check byte; optional inter-byte timeout under FRAME_TIMEOUT_EN
module spi_frame_assembler #(
    parameter int ERR_W   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_strobe,
    input  logic [7:0]       rx_byte,
    input  logic             SSEL,
    output logic [23:0]      word_data,
    output logic             word_valid,
    output logic             parity_ok,
    output logic             frame_err,
    output logic [ERR_W-1:0] err_count,
    output logic [31:0]      sent_data
);

    typedef enum logic [1:0] {IDX0, IDX1, IDX2, IDX3} idx_t;

    idx_t        idx;
    idx_t        idx_cap;
    idx_t        idx_next;
    logic        cap_pend;
    logic        ssel_meta;
    logic        ssel_sync;
    logic        ssel_prev;
    logic        deselect;
    logic [23:0] shadow;
    logic [7:0]  calc;
    logic        check_good;
    logic        complete;
    logic        short_err;
    logic        tmo_expire;
    logic        err_next;

    assign deselect   = ssel_sync & ~ssel_prev;
    assign calc       = shadow[23:16] ^ shadow[15:8] ^ shadow[7:0];
    assign check_good = (rx_byte == calc);
    assign complete   = cap_pend && (idx == IDX3);
    assign err_next   = short_err | tmo_expire | (complete & ~check_good);

`ifdef FRAME_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // A capture always beats expiry; the counter only matters mid-frame.
    assign tmo_expire = (idx != IDX0) && !cap_pend && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    // Inter-byte idle counter: restarts on every capture, parked while idle at IDX0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (cap_pend || idx_next == IDX0) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    // Without the timer a partial frame waits for bytes or a deselect; TIMEOUT is inert.
    assign tmo_expire = 1'b0 & (TIMEOUT == 0);
`endif

    // Strobe delay and SSEL synchroniser with edge register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_pend  <= 1'b0;
            ssel_meta <= 1'b1;
            ssel_sync <= 1'b1;
            ssel_prev <= 1'b1;
        end else begin
            cap_pend  <= rx_strobe;
            ssel_meta <= SSEL;
            ssel_sync <= ssel_meta;
            ssel_prev <= ssel_sync;
        end
    end

    // Byte index state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= IDX0;
        end else begin
            idx <= idx_next;
        end
    end

    // Next index: the capture advances first, then a deselect or timeout folds back to IDX0
    always_comb begin
        idx_cap   = idx;
        short_err = 1'b0;
        if (cap_pend) begin
            case (idx)
                IDX0:    idx_cap = IDX1;
                IDX1:    idx_cap = IDX2;
                IDX2:    idx_cap = IDX3;
                default: idx_cap = IDX0;
            endcase
        end
        idx_next = idx_cap;
        if (deselect) begin
            short_err = (idx_cap != IDX0);
            idx_next  = IDX0;
        end
        if (tmo_expire) begin
            idx_next = IDX0;
        end
    end

    // Shadow word collects b0..b2 MSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (cap_pend) begin
            case (idx)
                IDX0:    shadow[23:16] <= rx_byte;
                IDX1:    shadow[15:8]  <= rx_byte;
                IDX2:    shadow[7:0]   <= rx_byte;
                default: shadow        <= shadow;
            endcase
        end
    end

    // Frame report, reply word and saturating error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_data  <= '0;
            word_valid <= 1'b0;
            parity_ok  <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= '0;
            sent_data  <= '0;
        end else begin
            word_valid <= complete;
            frame_err  <= err_next;
            if (complete) begin
                word_data <= shadow;
                parity_ok <= check_good;
                if (check_good) begin
                    sent_data <= {shadow, calc};
                end
            end
            if (err_next && (err_count != {ERR_W{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_assembler.sv
// tb/tb_spi_frame_assembler.sv - scoreboard bench for spi_frame_assembler
module tb_spi_frame_assembler;

    logic        clk;
    logic        rst_n;
    logic        rx_strobe;
    logic [7:0]  rx_byte;
    logic        SSEL;
    logic [23:0] word_data;
    logic        word_valid;
    logic        parity_ok;
    logic        frame_err;
    logic [7:0]  err_count;
    logic [31:0] sent_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wv;
        logic [23:0] data;
        logic        pok;
        logic        ferr;
        logic [31:0] sent;
        logic [7:0]  errc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_sent = 32'h0;
    logic [7:0]  m_errc = 8'h0;

    spi_frame_assembler #(.ERR_W(8), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_strobe  (rx_strobe),
        .rx_byte    (rx_byte),
        .SSEL       (SSEL),
        .word_data  (word_data),
        .word_valid (word_valid),
        .parity_ok  (parity_ok),
        .frame_err  (frame_err),
        .err_count  (err_count),
        .sent_data  (sent_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bump_err();
        if (m_errc != 8'hFF) m_errc = m_errc + 8'd1;
    endtask

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] c);
        exp_t        e;
        logic [7:0]  x;
        x = b0 ^ b1 ^ b2;
        e.wv   = 1'b1;
        e.data = {b0, b1, b2};
        e.pok  = (c == x);
        e.ferr = (c != x);
        if (c == x) m_sent = {b0, b1, b2, x};
        else        bump_err();
        e.sent = m_sent;
        e.errc = m_errc;
        sb.push_back(e);
    endtask

    task automatic push_short();
        exp_t e;
        bump_err();
        e.wv   = 1'b0;
        e.data = 24'h0;
        e.pok  = 1'b0;
        e.ferr = 1'b1;
        e.sent = m_sent;
        e.errc = m_errc;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1 rx_strobe = 1'b1;
        @(posedge clk); #1 rx_strobe = 1'b0; rx_byte = b;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] c);
        push_frame(b0, b1, b2, c);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(c);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every reported frame or error pops one expectation
    always @(negedge clk) begin
        if (rst_n && (word_valid || frame_err)) begin
            if (sb.size() == 0) begin
                check("unexpected_event", {30'h0, word_valid, frame_err}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("word_valid", {31'h0, word_valid}, {31'h0, e.wv});
                check("frame_err", {31'h0, frame_err}, {31'h0, e.ferr});
                check("sent_data", sent_data, e.sent);
                check("err_count", {24'h0, err_count}, {24'h0, e.errc});
                if (e.wv) begin
                    check("word_data", {8'h0, word_data}, {8'h0, e.data});
                    check("parity_ok", {31'h0, parity_ok}, {31'h0, e.pok});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        rx_strobe = 1'b0;
        rx_byte   = 8'h0;
        SSEL      = 1'b0;
        idle(3);
        check("rst_word_data", {8'h0, word_data}, 32'h0);
        check("rst_word_valid", {31'h0, word_valid}, 32'h0);
        check("rst_parity_ok", {31'h0, parity_ok}, 32'h0);
        check("rst_frame_err", {31'h0, frame_err}, 32'h0);
        check("rst_err_count", {24'h0, err_count}, 32'h0);
        check("rst_sent_data", sent_data, 32'h0);
        rst_n = 1'b1;
        idle(4);

        // Good frame with explicit pulse timing
        send_frame(8'h12, 8'h34, 8'h56, 8'h70);
        check("wv_latency", {31'h0, word_valid}, 32'h1);
        idle(1);
        check("wv_width", {31'h0, word_valid}, 32'h0);
        idle(2);

        // Bad check byte
        send_frame(8'h12, 8'h34, 8'h56, 8'h71);
        idle(3);

        // Short frame closed by deselect, then a good frame
        send_byte(8'hAA);
        send_byte(8'hBB);
        push_short();
        SSEL = 1'b1;
        idle(6);
        SSEL = 1'b0;
        idle(4);
        send_frame(8'h01, 8'h02, 8'h03, 8'h00);
        idle(3);

        // Deselect edge lands in the capture cycle of the check byte
        push_frame(8'hA5, 8'h5A, 8'h3C, 8'hC3);
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(8'h3C);
        SSEL = 1'b1;
        send_byte(8'hC3);
        idle(4);
        SSEL = 1'b0;
        idle(4);
        send_frame(8'h11, 8'h22, 8'h44, 8'h77);
        idle(3);

        // Reset mid-frame
        send_byte(8'h55);
        send_byte(8'h66);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("midrst_word_data", {8'h0, word_data}, 32'h0);
        check("midrst_parity_ok", {31'h0, parity_ok}, 32'h0);
        check("midrst_err_count", {24'h0, err_count}, 32'h0);
        check("midrst_sent_data", sent_data, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        m_sent = 32'h0;
        m_errc = 8'h0;
        idle(4);
        send_frame(8'hFF, 8'h00, 8'h0F, 8'hF0);
        idle(3);

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            send_frame(i[7:0], 8'h01, 8'h02, i[7:0]);
        end
        idle(3);
        check("err_saturated", {24'h0, err_count}, 32'hFF);

`ifdef FRAME_TIMEOUT_EN
        push_short();
        send_byte(8'h99);
        idle(20);
        send_frame(8'h01, 8'h02, 8'h03, 8'h00);
        idle(3);
`endif

        idle(5);
        check("scoreboard_empty", sb.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
